// File: rtl/wb_port_arbiter_if.sv
// Writeback arbiter bus: ALU/memory write requests, decode hazard query and the
// registered register-file write port.
interface wb_port_arbiter_if #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_W     = 4
);
  logic                  a_valid;
  logic [ADDR_W-1:0]     a_dest;
  logic [WORD_WIDTH-1:0] a_data;
  logic                  a_ready;

  logic                  m_valid;
  logic [ADDR_W-1:0]     m_dest;
  logic [WORD_WIDTH-1:0] m_data;
  logic                  m_ready;

  logic                  flush;

  logic [ADDR_W-1:0]     src1;
  logic [ADDR_W-1:0]     src2;
  logic                  use1;
  logic                  use2;
  logic                  hazard;

  logic                  WB_en;
  logic [ADDR_W-1:0]     WB_dest;
  logic [WORD_WIDTH-1:0] WB_result;

  modport slave (
    input  a_valid, a_dest, a_data, m_valid, m_dest, m_data, flush,
           src1, src2, use1, use2,
    output a_ready, m_ready, hazard, WB_en, WB_dest, WB_result
  );

  modport master (
    output a_valid, a_dest, a_data, m_valid, m_dest, m_data, flush,
           src1, src2, use1, use2,
    input  a_ready, m_ready, hazard, WB_en, WB_dest, WB_result
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register file write port between ALU and memory writeback, oldest
// buffered write first, and flags read-after-write hazards for decode.
module wb_port_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_W     = 4
) (
  input logic               clk,
  input logic               rst,
  wb_port_arbiter_if.slave  port
);

  logic                  a_buf_valid;
  logic [ADDR_W-1:0]     a_buf_dest;
  logic [WORD_WIDTH-1:0] a_buf_data;
  logic                  m_buf_valid;
  logic [ADDR_W-1:0]     m_buf_dest;
  logic [WORD_WIDTH-1:0] m_buf_data;
  logic                  m_older;

  logic                  wb_en_q;
  logic [ADDR_W-1:0]     wb_dest_q;
  logic [WORD_WIDTH-1:0] wb_result_q;

  logic grant_a;
  logic grant_m;
  logic load_a;
  logic load_m;
  logic a_next_valid;
  logic m_next_valid;
  logic m_older_next;
  logic pend1;
  logic pend2;

  // Grant depends on buffer state only; a tie (loaded together) sets m_older.
  always_comb begin
    grant_a = a_buf_valid & (!m_buf_valid | !m_older);
    grant_m = m_buf_valid & (!a_buf_valid | m_older);
  end

  assign port.a_ready = !port.flush & (!a_buf_valid | grant_a);
  assign port.m_ready = !port.flush & (!m_buf_valid | grant_m);
  assign load_a       = port.a_valid & port.a_ready;
  assign load_m       = port.m_valid & port.m_ready;

  // With only one survivor the age bit simply points at it; with two, the one
  // that was not reloaded this edge is the older.
  always_comb begin
    a_next_valid = !port.flush & (load_a | (a_buf_valid & !grant_a));
    m_next_valid = !port.flush & (load_m | (m_buf_valid & !grant_m));
    m_older_next = m_next_valid;
    if (a_next_valid && m_next_valid) begin
      if (load_a) begin
        m_older_next = 1'b1;
      end else if (load_m) begin
        m_older_next = 1'b0;
      end else begin
        m_older_next = m_older;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_buf_valid <= 1'b0;
      a_buf_dest  <= '0;
      a_buf_data  <= '0;
      m_buf_valid <= 1'b0;
      m_buf_dest  <= '0;
      m_buf_data  <= '0;
      m_older     <= 1'b0;
    end else begin
      a_buf_valid <= a_next_valid;
      m_buf_valid <= m_next_valid;
      m_older     <= m_older_next;
      if (load_a) begin
        a_buf_dest <= port.a_dest;
        a_buf_data <= port.a_data;
      end
      if (load_m) begin
        m_buf_dest <= port.m_dest;
        m_buf_data <= port.m_data;
      end
    end
  end

  // A flush does not cancel the write granted in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q     <= 1'b0;
      wb_dest_q   <= '0;
      wb_result_q <= '0;
    end else begin
      wb_en_q <= grant_a | grant_m;
      if (grant_m) begin
        wb_dest_q   <= m_buf_dest;
        wb_result_q <= m_buf_data;
      end else if (grant_a) begin
        wb_dest_q   <= a_buf_dest;
        wb_result_q <= a_buf_data;
      end
    end
  end

  assign port.WB_en     = wb_en_q;
  assign port.WB_dest   = wb_dest_q;
  assign port.WB_result = wb_result_q;

  always_comb begin
    pend1 = (a_buf_valid & (a_buf_dest == port.src1)) |
            (m_buf_valid & (m_buf_dest == port.src1)) |
            (wb_en_q     & (wb_dest_q  == port.src1));
    pend2 = (a_buf_valid & (a_buf_dest == port.src2)) |
            (m_buf_valid & (m_buf_dest == port.src2)) |
            (wb_en_q     & (wb_dest_q  == port.src2));
  end

  assign port.hazard = (port.use1 & pend1) | (port.use2 & pend2);

endmodule
